// File: rtl/bcd_to_binary_if.sv
// Handshake and data bundle for bcd_to_binary: start plus five BCD digits in,
// converted value with busy/done/overflow/error status out.
interface bcd_to_binary_if #(
    parameter int N = 10
);
    logic         start;
    logic [3:0]   ones;
    logic [3:0]   tens;
    logic [3:0]   hundreds;
    logic [3:0]   thousands;
    logic [3:0]   tenThousands;
    logic [N-1:0] value;
    logic         busy;
    logic         done;
    logic         overflow;
    logic         error;

    modport master (
        output start, ones, tens, hundreds, thousands, tenThousands,
        input  value, busy, done, overflow, error
    );

    modport slave (
        input  start, ones, tens, hundreds, thousands, tenThousands,
        output value, busy, done, overflow, error
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Five-digit BCD to N-bit binary converter, reverse double-dabble, 21-cycle latency.
// Optional build macro BCD_SATURATE_EN: clamp overflowing results to 2^N-1 instead of wrapping.

module bcd_dig_fix (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd8) ? d - 4'd3 : d;
endmodule

module bcd_to_binary #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    bcd_to_binary_if.slave bus
);
    localparam int NDIG   = 5;
    localparam int SHIFTS = 4 * NDIG;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t       state_q, state_nx;
    logic         accept, do_shift, finish;
    logic [19:0]  dig_q, res_q, dig_sh, dig_fix;
    logic [4:0]   cnt_q;
    logic         err_q, dig_err;
    logic [N-1:0] value_q, val_c;
    logic         busy_q, done_q, ovf_q, errout_q, ovf_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        accept   = 1'b0;
        do_shift = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                accept   = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: if (cnt_q == 5'(SHIFTS)) begin
                finish   = 1'b1;
                state_nx = DONE;
            end else begin
                do_shift = 1'b1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Digit LSB falls into the result MSB; each digit field is then corrected.
    assign dig_sh = {1'b0, dig_q[19:1]};

    for (genvar g = 0; g < NDIG; g++) begin : g_fix
        bcd_dig_fix u_fix (
            .d (dig_sh[4*g +: 4]),
            .q (dig_fix[4*g +: 4])
        );
    end

    assign dig_err = (bus.ones > 4'd9) || (bus.tens > 4'd9) || (bus.hundreds > 4'd9) ||
                     (bus.thousands > 4'd9) || (bus.tenThousands > 4'd9);

    // Overflow looks at every result bit above N, never at a truncated copy.
    assign ovf_c = ~err_q & (|(res_q >> N));

    always_comb begin
        val_c = res_q[N-1:0];
        if (err_q) begin
            val_c = '0;
        end else if (ovf_c) begin
`ifdef BCD_SATURATE_EN
            val_c = '1;
`else
            val_c = res_q[N-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_q    <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            value_q  <= '0;
            ovf_q    <= 1'b0;
            errout_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= finish;
            if (accept) begin
                dig_q <= {bus.tenThousands, bus.thousands, bus.hundreds, bus.tens, bus.ones};
                res_q <= '0;
                cnt_q <= '0;
                err_q <= dig_err;
            end
            if (do_shift) begin
                dig_q <= dig_fix;
                res_q <= {dig_q[0], res_q[19:1]};
                cnt_q <= cnt_q + 5'd1;
            end
            if (finish) begin
                value_q  <= val_c;
                ovf_q    <= ovf_c;
                errout_q <= err_q;
            end
        end
    end

    assign bus.value    = value_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.error    = errout_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Bench for bcd_to_binary: N=10 and N=17 instances share stimulus, a decimal
// arithmetic model predicts every output each cycle, directed literals pin the model.
module tb_bcd_to_binary;
    localparam int NA = 10;
    localparam int NB = 17;
`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int v;
        bit o;
        bit e;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [19:0] digs;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bcd_to_binary_if #(.N(NA)) ia ();
    bcd_to_binary_if #(.N(NB)) ib ();

    assign ia.start = start;
    assign ia.ones = digs[3:0];
    assign ia.tens = digs[7:4];
    assign ia.hundreds = digs[11:8];
    assign ia.thousands = digs[15:12];
    assign ia.tenThousands = digs[19:16];
    assign ib.start = start;
    assign ib.ones = digs[3:0];
    assign ib.tens = digs[7:4];
    assign ib.hundreds = digs[11:8];
    assign ib.thousands = digs[15:12];
    assign ib.tenThousands = digs[19:16];

    bcd_to_binary #(.N(NA)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia.slave));
    bcd_to_binary #(.N(NB)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input int n, input logic [19:0] dg);
        res_t r;
        int   d;
        int   maxv;
        bit   e;
        d = 0;
        e = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            int x;
            x = int'(dg[i*4 +: 4]);
            if (x > 9) e = 1'b1;
            d = d * 10 + x;
        end
        maxv = (1 << n) - 1;
        r.e = e;
        r.o = !e && (d > maxv);
        if (e)        r.v = 0;
        else if (!r.o) r.v = d;
        else if (SAT) r.v = maxv;
        else          r.v = d % (1 << n);
        return r;
    endfunction

    // Cycle-level model: edges since the accepting edge, results appear 21 edges later.
    int   mk = -1;
    res_t pa, pb;
    res_t ea = '{0, 0, 0};
    res_t eb = '{0, 0, 0};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mk = -1;
            ea = '{0, 0, 0};
            eb = '{0, 0, 0};
        end else if (mk < 0) begin
            if (start) begin
                mk = 0;
                pa = model(NA, digs);
                pb = model(NB, digs);
            end
        end else begin
            mk++;
            if (mk == 21) begin
                ea = pa;
                eb = pb;
            end
            if (mk == 22) mk = -1;
        end
    end

    always @(negedge clk) begin
        chk("busy_a", 32'(ia.busy), 32'(mk >= 0));
        chk("done_a", 32'(ia.done), 32'(mk == 21));
        chk("value_a", 32'(ia.value), ea.v);
        chk("ovf_a", 32'(ia.overflow), 32'(ea.o));
        chk("err_a", 32'(ia.error), 32'(ea.e));
        chk("busy_b", 32'(ib.busy), 32'(mk >= 0));
        chk("done_b", 32'(ib.done), 32'(mk == 21));
        chk("value_b", 32'(ib.value), eb.v);
        chk("ovf_b", 32'(ib.overflow), 32'(eb.o));
        chk("err_b", 32'(ib.error), 32'(eb.e));
    end

    task automatic run(input string nm, input logic [19:0] dg, input int va, input int oa,
                       input int er, input int vb, input int ob);
        int lat;
        int blen;
        lat  = -1;
        blen = 0;
        @(negedge clk);
        digs  = dg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        digs  = 20'hFFFFF;
        if (ia.busy) blen++;
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk);
            if (ia.done && lat < 0) lat = i;
            if (ia.busy) blen++;
            start = (i == 5 || i == 21);
        end
        start = 1'b0;
        chk({nm, "_latency"}, lat, 21);
        chk({nm, "_busylen"}, blen, 22);
        chk({nm, "_value_a"}, 32'(ia.value), va);
        chk({nm, "_ovf_a"}, 32'(ia.overflow), oa);
        chk({nm, "_err_a"}, 32'(ia.error), er);
        chk({nm, "_value_b"}, 32'(ib.value), vb);
        chk({nm, "_ovf_b"}, 32'(ib.overflow), ob);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        reset_n = 1'b1;
        start   = 1'b0;
        digs    = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_value", 32'(ia.value), 0);
        chk("rst_busy", 32'(ia.busy), 0);
        chk("rst_done", 32'(ia.done), 0);
        reset_n = 1'b1;

        run("c999", 20'h00999, 999, 0, 0, 999, 0);
        run("c1023", 20'h01023, 1023, 0, 0, 1023, 0);
        run("c1024", 20'h01024, SAT ? 1023 : 0, 1, 0, 1024, 0);
        run("c99999", 20'h99999, SAT ? 1023 : 671, 1, 0, 99999, 0);
        run("errA", 20'h000A0, 0, 0, 1, 0, 0);

        @(negedge clk);
        digs  = 20'h12345;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(ia.busy), 0);
        chk("midrst_value", 32'(ia.value), 0);
        chk("midrst_err", 32'(ia.error), 0);
        chk("midrst_value_b", 32'(ib.value), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (ia.done || ib.done) seen = 1;
        end
        chk("midrst_nodone", seen, 0);

        run("c42", 20'h00042, 42, 0, 0, 42, 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
